// File: rtl/uart_instr_loader.sv
// UART instruction loader: pairs received bytes into 16-bit words (high byte
// first), writes them to consecutive instruction-memory addresses and flags
// the end of a program load once the line has been silent long enough.
module uart_instr_loader #(
    parameter int unsigned MAX_DELAY_TOLERANCE = 3,
    parameter int unsigned CYCLES_PER_BYTE     = 8680,
    parameter int unsigned ADDR_W              = 8,
    parameter int unsigned START_ADDR          = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_valid,
    output logic              o_mem_wr_en,
    output logic [ADDR_W-1:0] o_mem_wr_addr,
    output logic [15:0]       o_mem_wr_data,
    output logic [ADDR_W-1:0] o_max_addr_instr,
    output logic              o_instr_transmit_done,
    output logic              o_frame_err,
    output logic              o_overflow
);

    localparam int unsigned LIMIT = MAX_DELAY_TOLERANCE * CYCLES_PER_BYTE;
    localparam int unsigned TW    = $clog2(LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        GOT_HIGH,
        WORD_WAIT,
        DONE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [TW-1:0]   timer;
    logic [7:0]      high_byte;
    // One extra bit so the address saturates at 2^ADDR_W instead of wrapping.
    logic [ADDR_W:0] next_addr;
    logic            any_written;

    logic latch_high;
    logic word_done;
    logic timer_run;
    logic timer_clr;
    logic set_done;
    logic set_ferr;
    logic timeout;

    assign timeout = (timer == TW'(LIMIT - 1));

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and control decode; a received byte always beats a timeout.
    always_comb begin
        state_next = state;
        latch_high = 1'b0;
        word_done  = 1'b0;
        timer_run  = 1'b0;
        timer_clr  = 1'b0;
        set_done   = 1'b0;
        set_ferr   = 1'b0;
        case (state)
            IDLE: begin
                if (i_rx_valid) begin
                    latch_high = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = GOT_HIGH;
                end
            end
            GOT_HIGH: begin
                if (i_rx_valid) begin
                    word_done  = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = WORD_WAIT;
                end else if (timeout) begin
                    set_ferr  = 1'b1;
                    timer_clr = 1'b1;
                    if (any_written) begin
                        set_done   = 1'b1;
                        state_next = DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    timer_run = 1'b1;
                end
            end
            WORD_WAIT: begin
                if (i_rx_valid) begin
                    latch_high = 1'b1;
                    timer_clr  = 1'b1;
                    state_next = GOT_HIGH;
                end else if (timeout) begin
                    set_done   = 1'b1;
                    state_next = DONE;
                end else begin
                    timer_run = 1'b1;
                end
            end
            DONE: begin
                state_next = DONE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: silence timer, byte pairing, memory write and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer                 <= '0;
            high_byte             <= '0;
            next_addr             <= (ADDR_W + 1)'(START_ADDR);
            any_written           <= 1'b0;
            o_mem_wr_en           <= 1'b0;
            o_mem_wr_addr         <= '0;
            o_mem_wr_data         <= '0;
            o_max_addr_instr      <= '0;
            o_instr_transmit_done <= 1'b0;
            o_frame_err           <= 1'b0;
            o_overflow            <= 1'b0;
        end else begin
            o_mem_wr_en <= 1'b0;

            if (timer_clr) begin
                timer <= '0;
            end else if (timer_run && (timer != TW'(LIMIT))) begin
                timer <= timer + TW'(1);
            end

            if (latch_high) begin
                high_byte <= i_rx_data;
            end

            if (set_done) begin
                o_instr_transmit_done <= 1'b1;
            end
            if (set_ferr) begin
                o_frame_err <= 1'b1;
            end

            if (word_done) begin
                if (next_addr[ADDR_W]) begin
                    o_overflow <= 1'b1;
                end else begin
                    o_mem_wr_en      <= 1'b1;
                    o_mem_wr_addr    <= next_addr[ADDR_W-1:0];
                    o_mem_wr_data    <= {high_byte, i_rx_data};
                    o_max_addr_instr <= next_addr[ADDR_W-1:0];
                    next_addr        <= next_addr + (ADDR_W + 1)'(1);
                    any_written      <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Self-checking bench for uart_instr_loader: a scoreboard of expected memory
// writes (address, data, cycle) checked by a write monitor, plus flag checks.
module tb_uart_instr_loader;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = '0;
    logic       rx_valid = 1'b0;
    int unsigned sel = 0;   // 0: fast timing, 1: full default timing, 2: ADDR_W=2
    int unsigned cyc = 0;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    logic v_f, v_d, v_o;
    assign v_f = rx_valid && (sel == 0);
    assign v_d = rx_valid && (sel == 1);
    assign v_o = rx_valid && (sel == 2);

    logic       wr_f, done_f, ferr_f, ovf_f;
    logic [7:0] addr_f, max_f;
    logic [15:0] data_f;
    logic       wr_d, done_d, ferr_d, ovf_d;
    logic [7:0] addr_d, max_d;
    logic [15:0] data_d;
    logic       wr_o, done_o, ferr_o, ovf_o;
    logic [1:0] addr_o, max_o;
    logic [15:0] data_o;

    uart_instr_loader #(.CYCLES_PER_BYTE(16)) u_fast (
        .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(v_f),
        .o_mem_wr_en(wr_f), .o_mem_wr_addr(addr_f), .o_mem_wr_data(data_f),
        .o_max_addr_instr(max_f), .o_instr_transmit_done(done_f),
        .o_frame_err(ferr_f), .o_overflow(ovf_f)
    );

    uart_instr_loader u_full (
        .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(v_d),
        .o_mem_wr_en(wr_d), .o_mem_wr_addr(addr_d), .o_mem_wr_data(data_d),
        .o_max_addr_instr(max_d), .o_instr_transmit_done(done_d),
        .o_frame_err(ferr_d), .o_overflow(ovf_d)
    );

    uart_instr_loader #(.ADDR_W(2), .CYCLES_PER_BYTE(16)) u_ovf (
        .clk(clk), .rst_n(rst_n), .i_rx_data(rx_data), .i_rx_valid(v_o),
        .o_mem_wr_en(wr_o), .o_mem_wr_addr(addr_o), .o_mem_wr_data(data_o),
        .o_max_addr_instr(max_o), .o_instr_transmit_done(done_o),
        .o_frame_err(ferr_o), .o_overflow(ovf_o)
    );

    typedef struct {
        int unsigned cyc;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic observe(input logic [7:0] a, input logic [15:0] d);
        wr_t e;
        if (exp_q.size() == 0) begin
            check("wr_unexpected", {24'd0, a}, 32'hFFFF_FFFF);
        end else begin
            e = exp_q.pop_front();
            check("wr_cycle", cyc, e.cyc);
            check("wr_addr", {24'd0, a}, {24'd0, e.addr});
            check("wr_data", {16'd0, d}, {16'd0, e.data});
        end
    endtask

    // Write monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (wr_f) observe(addr_f, data_f);
        if (wr_d) observe(addr_d, data_d);
        if (wr_o) observe({6'd0, addr_o}, data_o);
    end

    // Called #1 after a rising edge; leaves the time #1 after the sampling edge.
    task automatic send(input logic [7:0] b, input bit wr, input logic [7:0] a,
                        input logic [15:0] d);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (wr) exp_q.push_back('{cyc, a, d});
    endtask

    task automatic wait_cycles(input int unsigned n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        check("rst_fast", {19'd0, wr_f, done_f, ferr_f, ovf_f, max_f}, 32'd0);
        check("rst_full", {19'd0, wr_d, done_d, ferr_d, ovf_d, max_d}, 32'd0);
        check("rst_ovf",  {25'd0, wr_o, done_o, ferr_o, ovf_o, max_o}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        wait_cycles(1);
    endtask

    logic [7:0] prog [22] = '{8'h41, 8'h26, 8'h81, 8'h80, 8'h41, 8'hC6, 8'h20, 8'h80,
                              8'h91, 8'h30, 8'h51, 8'hC0, 8'h81, 8'h40, 8'hD0, 8'h40,
                              8'h61, 8'hD0, 8'hC1, 8'h80, 8'hE0, 8'h00};

    initial begin
        int unsigned e0;
        int unsigned lat;
        bit seen;

        wait_cycles(2);

        // Single word with full-size timing: exact done latency.
        sel = 1;
        do_reset();
        send(8'h41, 0, 8'd0, 16'h0);
        send(8'h00, 1, 8'd1, 16'h4100);
        e0 = cyc;
        seen = 0;
        lat = 0;
        for (int j = 1; j <= 26100 && !seen; j++) begin
            @(posedge clk);
            #1;
            if (done_d) begin
                seen = 1;
                lat = cyc - e0;
            end
        end
        check("done_latency", lat, 32'd26040);
        check("full_max", {24'd0, max_d}, 32'd1);
        check("full_ferr", {31'd0, ferr_d}, 32'd0);

        // Full program load, back-to-back bytes.
        sel = 0;
        do_reset();
        for (int i = 0; i < 22; i += 2) begin
            send(prog[i], 0, 8'd0, 16'h0);
            send(prog[i+1], 1, 8'(i / 2 + 1), {prog[i], prog[i+1]});
        end
        wait_cycles(60);
        check("prog_max", {24'd0, max_f}, 32'd11);
        check("prog_done", {31'd0, done_f}, 32'd1);
        check("prog_ferr", {31'd0, ferr_f}, 32'd0);
        check("prog_ovf", {31'd0, ovf_f}, 32'd0);

        // Odd trailing byte after one word.
        do_reset();
        send(8'h41, 0, 8'd0, 16'h0);
        send(8'h26, 1, 8'd1, 16'h4126);
        send(8'h81, 0, 8'd0, 16'h0);
        wait_cycles(60);
        check("odd_ferr", {31'd0, ferr_f}, 32'd1);
        check("odd_done", {31'd0, done_f}, 32'd1);
        check("odd_max", {24'd0, max_f}, 32'd1);

        // Lone byte, then a fresh word; then a byte landing on the threshold.
        do_reset();
        send(8'h41, 0, 8'd0, 16'h0);
        wait_cycles(60);
        check("lone_ferr", {31'd0, ferr_f}, 32'd1);
        check("lone_done", {31'd0, done_f}, 32'd0);
        check("lone_max", {24'd0, max_f}, 32'd0);
        send(8'hE0, 0, 8'd0, 16'h0);
        send(8'h00, 1, 8'd1, 16'hE000);
        wait_cycles(47);
        send(8'h12, 0, 8'd0, 16'h0);
        check("edge_done", {31'd0, done_f}, 32'd0);
        send(8'h34, 1, 8'd2, 16'h1234);
        wait_cycles(60);
        check("edge_done_after", {31'd0, done_f}, 32'd1);
        check("edge_max", {24'd0, max_f}, 32'd2);

        // Bytes after done are ignored.
        send(8'h11, 0, 8'd0, 16'h0);
        send(8'h22, 0, 8'd0, 16'h0);
        wait_cycles(3);
        check("ign_max", {24'd0, max_f}, 32'd2);
        check("ign_flags", {29'd0, done_f, ferr_f, ovf_f}, 32'b110);

        // Reset mid-stream discards the pending high byte.
        send(8'h41, 0, 8'd0, 16'h0);
        do_reset();
        send(8'h41, 0, 8'd0, 16'h0);
        send(8'h00, 1, 8'd1, 16'h4100);
        wait_cycles(3);
        check("reload_max", {24'd0, max_f}, 32'd1);

        // Address overflow with ADDR_W=2.
        sel = 2;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            send(8'(8'hA0 + i), 0, 8'd0, 16'h0);
            send(8'(8'h10 + i), i < 3, 8'(i + 1), {8'(8'hA0 + i), 8'(8'h10 + i)});
        end
        wait_cycles(2);
        check("ovf_flag", {31'd0, ovf_o}, 32'd1);
        check("ovf_max", {30'd0, max_o}, 32'd3);
        wait_cycles(60);
        check("ovf_done", {31'd0, done_o}, 32'd1);

        check("sb_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
